// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, FSM states and decode helpers shared by the ALU blocks
package alu_pkg;
   typedef enum logic [4:0] {
      OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU, OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SUB,
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU,
      OP_REM, OP_REMU
   } op_e;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
   function automatic logic is_mul(input logic [4:0] op);
      return op >= OP_MUL && op <= OP_MULHU;
   endfunction
   function automatic logic is_div(input logic [4:0] op);
      return op >= OP_DIV && op <= OP_REMU;
   endfunction
   function automatic logic a_signed(input logic [4:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction
   function automatic logic b_signed(input logic [4:0] op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle compare/logic/add/shift datapath; flags codes beyond REMU as illegal
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             illegal
);
   localparam int SW = $clog2(WIDTH);
   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];
   assign illegal = op > OP_REMU;
   always_comb begin
      y = '0;
      case (op)
         OP_EQ:  y = WIDTH'(a == b);
         OP_NE:  y = WIDTH'(a != b);
         OP_LT:  y = WIDTH'($signed(a) < $signed(b));
         OP_GE:  y = WIDTH'($signed(a) >= $signed(b));
         OP_LTU: y = WIDTH'(a < b);
         OP_GEU: y = WIDTH'(a >= b);
         OP_ADD: y = a + b;
         OP_XOR: y = a ^ b;
         OP_OR:  y = a | b;
         OP_AND: y = a & b;
         OP_SUB: y = a - b;
         OP_SLL: y = a << sh;
         OP_SRL: y = a >> sh;
         OP_SRA: y = $unsigned($signed(a) >>> sh);
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative shift-add multiply and restoring divide.
// Mul/div run on magnitudes; one stored sign bit fixes up the result on entry to DONE.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [4:0]       operation,
   input  logic [WIDTH-1:0] dataIn0,
   input  logic [WIDTH-1:0] dataIn1,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] dataOut,
   output logic             illegalOp
);
   state_e state, state_nx;
   logic [2*WIDTH-1:0] acc, acc_nx, pfin;
   logic [WIDTH-1:0] bop, amag, bmag, comb_y, fast_val, qfin, rfin, done_val;
   logic [WIDTH:0] msum, dtrial, ddiff;
   logic [SHAMT_W:0] cnt;
   logic [4:0] op_r;
   logic neg, accept, last, busy, an, bn, div_zero, ovf, fast, rem_op, comb_ill;
   alu_comb #(.WIDTH(WIDTH)) u_comb (.op(operation), .a(dataIn0), .b(dataIn1), .y(comb_y), .illegal(comb_ill));
   assign accept   = inValid && inReady;
   assign busy     = state == S_MUL || state == S_DIV;
   assign last     = cnt == (SHAMT_W+1)'(WIDTH-1);
   assign an       = a_signed(operation) && dataIn0[WIDTH-1];
   assign bn       = b_signed(operation) && dataIn1[WIDTH-1];
   assign amag     = an ? -dataIn0 : dataIn0;
   assign bmag     = bn ? -dataIn1 : dataIn1;
   assign rem_op   = operation == OP_REM || operation == OP_REMU;
   assign div_zero = dataIn1 == '0;
   assign ovf      = (operation == OP_DIV || operation == OP_REM) && dataIn0 == {1'b1, {(WIDTH-1){1'b0}}} && &dataIn1;
   assign fast     = is_div(operation) && (div_zero || ovf);
   assign fast_val = div_zero ? (rem_op ? dataIn0 : '1) : (rem_op ? '0 : dataIn0);
   // mul: acc = {partial sum, shifting multiplier}; div: acc = {remainder, shifting dividend/quotient}
   assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bop} : '0);
   assign dtrial   = acc[2*WIDTH-1:WIDTH-1];
   assign ddiff    = dtrial - {1'b0, bop};
   assign acc_nx   = state == S_MUL ? {msum, acc[WIDTH-1:1]} :
                     ddiff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   assign pfin     = neg ? -acc_nx : acc_nx;
   assign qfin     = neg ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
   assign rfin     = neg ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
   assign done_val = state == S_MUL ? (op_r == OP_MUL ? pfin[WIDTH-1:0] : pfin[2*WIDTH-1:WIDTH]) :
                     (op_r == OP_REM || op_r == OP_REMU) ? rfin : qfin;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= state_nx;
   always_comb begin
      inReady  = state == S_IDLE || (state == S_DONE && outReady);
      outValid = state == S_DONE;
      state_nx = accept ? (is_mul(operation) ? S_MUL : is_div(operation) && !fast ? S_DIV : S_DONE) :
                 busy && last ? S_DONE :
                 state == S_DONE && outReady ? S_IDLE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc       <= '0;
         bop       <= '0;
         cnt       <= '0;
         op_r      <= OP_EQ;
         neg       <= 1'b0;
         dataOut   <= '0;
         illegalOp <= 1'b0;
      end else if (accept) begin
         acc       <= {{WIDTH{1'b0}}, is_mul(operation) ? bmag : amag};
         bop       <= is_mul(operation) ? amag : bmag;
         cnt       <= '0;
         op_r      <= operation;
         neg       <= operation == OP_REM ? an : an ^ bn;
         dataOut   <= is_div(operation) ? fast_val : comb_y;
         illegalOp <= comb_ill;
      end else if (busy) begin
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
         if (last) dataOut <= done_val;
      end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table plus stall/back-to-back/reset sequences, scoreboard-checked
module tb_alu_seq;
   import alu_pkg::*;
   typedef struct {logic [4:0] op; logic [31:0] a, b, e; logic il; int lat;} vec_t;
   typedef struct {logic [31:0] e; logic il; int lat; int c;} sb_t;
   logic clk = 0, rst = 1, inValid = 0, inReady, outValid, outReady = 1, illegalOp;
   logic [4:0] operation = 0;
   logic [31:0] dataIn0 = 0, dataIn1 = 0, dataOut, exp_e = 0;
   logic exp_il = 0;
   int exp_lat = 1, total = 0, bad = 0, cyc = 0;
   bit seen = 0;
   sb_t sb[$];
   vec_t v[$];
   alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
      .operation(operation), .dataIn0(dataIn0), .dataIn1(dataIn1), .outValid(outValid),
      .outReady(outReady), .dataOut(dataOut), .illegalOp(illegalOp));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         seen = 0;
      end else begin
         if (outValid && !seen) begin
            if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else chk("latency", cyc - sb[0].c, sb[0].lat);
            seen = 1;
         end
         if (outValid && outReady && sb.size() > 0) begin
            chk("data", dataOut, sb[0].e);
            chk("illegal", {31'd0, illegalOp}, {31'd0, sb[0].il});
            void'(sb.pop_front());
            seen = 0;
         end
         if (inValid && inReady) sb.push_back('{exp_e, exp_il, exp_lat, cyc});
      end
   end
   task automatic send(input logic [4:0] op, input logic [31:0] a, b, e, input logic il, input int lat);
      int n = 0;
      operation = op; dataIn0 = a; dataIn1 = b;
      exp_e = e; exp_il = il; exp_lat = lat;
      inValid = 1;
      #1;
      while (!inReady && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      inValid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); n++;
      end
      #1;
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask
   initial begin
      v.push_back('{OP_ADD,   32'd5,        32'd7,        32'd12,       0, 1});
      v.push_back('{OP_SRA,   32'h80000000, 32'd4,        32'hF8000000, 0, 1});
      v.push_back('{OP_SRL,   32'h80000000, 32'd36,       32'h08000000, 0, 1});
      v.push_back('{OP_SLL,   32'd1,        32'd31,       32'h80000000, 0, 1});
      v.push_back('{OP_SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 0, 1});
      v.push_back('{OP_LT,    32'hFFFFFFFF, 32'd1,        32'd1,        0, 1});
      v.push_back('{OP_LTU,   32'hFFFFFFFF, 32'd1,        32'd0,        0, 1});
      v.push_back('{OP_GE,    32'd3,        32'hFFFFFFFE, 32'd1,        0, 1});
      v.push_back('{OP_EQ,    32'd9,        32'd9,        32'd1,        0, 1});
      v.push_back('{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 1});
      v.push_back('{OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 0, 33});
      v.push_back('{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33});
      v.push_back('{OP_MUL,   32'd3,        32'hFFFFFFFC, 32'hFFFFFFF4, 0, 33});
      v.push_back('{OP_MULHSU,32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 33});
      v.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33});
      v.push_back('{OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33});
      v.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 33});
      v.push_back('{OP_REM,   32'd7,        32'hFFFFFFFE, 32'd1,        0, 33});
      v.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd14,       0, 33});
      v.push_back('{OP_REMU,  32'd100,      32'd7,        32'd2,        0, 33});
      v.push_back('{OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 0, 1});
      v.push_back('{OP_REMU,  32'd5,        32'd0,        32'd5,        0, 1});
      v.push_back('{OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 0, 1});
      v.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1});
      v.push_back('{OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1});
      v.push_back('{5'h16,    32'd1,        32'd2,        32'd0,        1, 1});
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outValid", {31'd0, outValid}, 32'd0);
      chk("rst_inReady", {31'd0, inReady}, 32'd1);
      chk("rst_dataOut", dataOut, 32'd0);
      chk("rst_illegal", {31'd0, illegalOp}, 32'd0);
      rst = 0;
      foreach (v[i]) begin
         send(v[i].op, v[i].a, v[i].b, v[i].e, v[i].il, v[i].lat);
         drain();
      end
      for (int i = 0; i < 4; i++) send(OP_ADD, 32'(i), 32'd100, 32'(i + 100), 0, 1);
      drain();
      outReady = 0;
      send(OP_ADD, 32'd2, 32'd3, 32'd5, 0, 1);
      for (int n = 0; n < 20 && !outValid; n++) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", {31'd0, outValid}, 32'd1);
         chk("stall_data", dataOut, 32'd5);
         @(posedge clk); #1;
      end
      operation = OP_ADD; dataIn0 = 32'd10; dataIn1 = 32'd20;
      exp_e = 32'd30; exp_il = 0; exp_lat = 1;
      inValid = 1; outReady = 1;
      #1;
      chk("b2b_inReady", {31'd0, inReady}, 32'd1);
      @(posedge clk); #1;
      inValid = 0;
      drain();
      send(OP_MUL, 32'd3, 32'd4, 32'd12, 0, 33);
      repeat (9) @(posedge clk);
      #1;
      chk("busy_inReady", {31'd0, inReady}, 32'd0);
      rst = 1;
      #1;
      chk("midrst_outValid", {31'd0, outValid}, 32'd0);
      chk("midrst_inReady", {31'd0, inReady}, 32'd1);
      @(posedge clk); #1;
      rst = 0;
      send(OP_ADD, 32'd1, 32'd1, 32'd2, 0, 1);
      drain();
      send(5'h1F, 32'd7, 32'd7, 32'd0, 1, 1);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
